// File: rtl/wildcard_match_engine.sv
// wildcard_match_engine
//   Two-stage pipelined wildcard matcher. Each accepted word is compared against
//   NUM_PAT programmable pattern/mask entries (mask bit 1 = don't care).
//   S1 registers the per-entry hit vector and an input X/Z flag. S2 registers
//   the encoded result: the hit vector, any_hit, and the lowest hitting index.
//   A saturating counter tracks delivered results that had any hit.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   cfg_*            pattern table write port (cfg_we strobes entry cfg_idx)
//   in_valid/ready   input handshake, in_data is the word to match
//   out_valid/ready  output handshake, out_* result fields
//   cnt_clr          synchronous clear of hit_count (wins over increment)
//   hit_count        saturating count of hit results delivered downstream
module wildcard_match_engine #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_PAT = 4,
  parameter int unsigned XZ_WILD = 0,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]   cfg_pattern,
  input  logic [WIDTH-1:0]   cfg_mask,
  input  logic               cfg_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_PAT-1:0] out_hit_vec,
  output logic               out_any_hit,
  output logic [IDX_W-1:0]   out_first_idx,
  output logic               out_xz,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_count
);

  localparam logic XzWildEn = (XZ_WILD != 0);

  // Pattern table
  logic [WIDTH-1:0]   pat_q  [NUM_PAT];
  logic [WIDTH-1:0]   mask_q [NUM_PAT];
  logic [NUM_PAT-1:0] en_q;

  // Pipeline state
  logic               s1_valid_q;
  logic [NUM_PAT-1:0] s1_hit_q;
  logic               s1_xz_q;
  logic               s2_valid_q;
  logic [NUM_PAT-1:0] s2_hit_q;
  logic               s2_any_q;
  logic [IDX_W-1:0]   s2_idx_q;
  logic               s2_xz_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               s1_adv;
  logic               s2_adv;
  logic [WIDTH-1:0]   xz_bits;
  logic               xz_d;
  logic [NUM_PAT-1:0] hit_d;
  logic [IDX_W-1:0]   first_idx_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        pat_q[i]  <= '0;
        mask_q[i] <= '0;
      end
      en_q <= '0;
    end else if (cfg_we && (32'(cfg_idx) < NUM_PAT)) begin
      pat_q[cfg_idx]  <= cfg_pattern;
      mask_q[cfg_idx] <= cfg_mask;
      en_q[cfg_idx]   <= cfg_en;
    end
  end

  // A bit that is neither 0 nor 1 is X or Z; always 0 in a 2-state simulator.
  always_comb begin
    xz_bits = '0;
    for (int b = 0; b < WIDTH; b++) begin
      xz_bits[b] = (in_data[b] !== 1'b0) && (in_data[b] !== 1'b1);
    end
    xz_d = |xz_bits;
  end

  // Case equality: an X/Z input bit never equals a 0/1 pattern bit unless
  // XZ_WILD turns such bits into wildcards.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      hit_d[i] = en_q[i];
      for (int b = 0; b < WIDTH; b++) begin
        hit_d[i] = hit_d[i] & (mask_q[i][b] | (in_data[b] === pat_q[i][b]) |
                               (XzWildEn & xz_bits[b]));
      end
    end
  end

  // Lowest index wins: scan from the top so the lowest hit overwrites last.
  always_comb begin
    first_idx_d = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        first_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      s1_xz_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= '0;
      s2_any_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_xz_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_hit_q <= hit_d;
          s1_xz_q  <= xz_d;
        end
      end
      // Result fields only load with a new word, so they hold while stalled.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_hit_q <= s1_hit_q;
          s2_any_q <= |s1_hit_q;
          s2_idx_q <= first_idx_d;
          s2_xz_q  <= s1_xz_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_any_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_hit_vec   = s2_hit_q;
  assign out_any_hit   = s2_any_q;
  assign out_first_idx = s2_idx_q;
  assign out_xz        = s2_xz_q;
  assign hit_count     = cnt_q;

endmodule
